fp_input_arbiter: RTL and testbench

Clocked two-input merge arbiter in front of the FP (function-processing) stage. Two upstream packet channels share the FP stage's single Send/Ack input. Channel 0 is the matching-stage output; channel 1 is the external or injection path. The block grants one channel at a time with round-robin fairness and buffers the granted packet in a holding register. It drops packets flagged for deletion and keeps per-channel grant and drop statistics.

---
 rtl/fp_input_arbiter.sv | 156 +++++++++++++++
 tb/tb_fp_input_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_input_arbiter.sv
// Two-channel round-robin merge arbiter feeding the FP stage over 4-phase Send/Ack.
// Holds the granted packet in a buffer, discards delete-flagged packets and keeps saturating statistics.
module fp_input_arbiter #(
    parameter int PACK_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              MR,
    input  logic              Send_in0,
    input  logic [PACK_W-1:0] PACKET_IN0,
    input  logic              DEL0,
    output logic              Ack_out0,
    input  logic              Send_in1,
    input  logic [PACK_W-1:0] PACKET_IN1,
    input  logic              DEL1,
    output logic              Ack_out1,
    output logic              Send_out,
    input  logic              Ack_in,
    output logic [PACK_W-1:0] PACKET_OUT,
    input  logic              CNT_CLR,
    output logic [CNT_W-1:0]  GNT_CNT0,
    output logic [CNT_W-1:0]  GNT_CNT1,
    output logic [CNT_W-1:0]  DROP_CNT
);

    typedef enum logic [1:0] {IDLE, CAPT, OUT_REQ, OUT_REL} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               del_q, del_d;
    logic [PACK_W-1:0]  buf_q, buf_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               send_out_q, send_out_d;
    logic [CNT_W-1:0]   gnt_cnt0_q, gnt_cnt0_d;
    logic [CNT_W-1:0]   gnt_cnt1_q, gnt_cnt1_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic               grant_ch;
    logic               inc0, inc1, inc_drop;
    logic               cur_send;

    // last_grant_q doubles as the channel currently being served once out of IDLE
    assign cur_send = last_grant_q ? Send_in1 : Send_in0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        del_d        = del_q;
        buf_d        = buf_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        send_out_d   = send_out_q;
        grant_ch     = 1'b0;
        inc0         = 1'b0;
        inc1         = 1'b0;
        inc_drop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Send_in0 || Send_in1) begin
                    grant_ch     = (Send_in0 && Send_in1) ? ~last_grant_q : Send_in1;
                    last_grant_d = grant_ch;
                    buf_d        = grant_ch ? PACKET_IN1 : PACKET_IN0;
                    del_d        = grant_ch ? DEL1 : DEL0;
                    if (grant_ch) begin
                        ack1_d = 1'b1;
                        inc1   = 1'b1;
                    end else begin
                        ack0_d = 1'b1;
                        inc0   = 1'b1;
                    end
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (!cur_send) begin
                    ack0_d = 1'b0;
                    ack1_d = 1'b0;
                    if (del_q) begin
                        inc_drop = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        send_out_d = 1'b1;
                        state_d    = OUT_REQ;
                    end
                end
            end
            OUT_REQ: begin
                if (Ack_in) begin
                    send_out_d = 1'b0;
                    state_d    = OUT_REL;
                end
            end
            OUT_REL: begin
                if (!Ack_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear wins over an increment landing on the same edge
    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        drop_cnt_d = drop_cnt_q;
        if (CNT_CLR) begin
            gnt_cnt0_d = '0;
            gnt_cnt1_d = '0;
            drop_cnt_d = '0;
        end else begin
            if (inc0 && gnt_cnt0_q != CNT_MAX) gnt_cnt0_d = gnt_cnt0_q + CNT_ONE;
            if (inc1 && gnt_cnt1_q != CNT_MAX) gnt_cnt1_d = gnt_cnt1_q + CNT_ONE;
            if (inc_drop && drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            del_q        <= 1'b0;
            buf_q        <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            send_out_q   <= 1'b0;
            gnt_cnt0_q   <= '0;
            gnt_cnt1_q   <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            del_q        <= del_d;
            buf_q        <= buf_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            send_out_q   <= send_out_d;
            gnt_cnt0_q   <= gnt_cnt0_d;
            gnt_cnt1_q   <= gnt_cnt1_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign Ack_out0   = ack0_q;
    assign Ack_out1   = ack1_q;
    assign Send_out   = send_out_q;
    assign PACKET_OUT = buf_q;
    assign GNT_CNT0   = gnt_cnt0_q;
    assign GNT_CNT1   = gnt_cnt1_q;
    assign DROP_CNT   = drop_cnt_q;

endmodule

// File: tb/tb_fp_input_arbiter.sv
// Bench for fp_input_arbiter: a cycle table, directed corner sequences, and reactive random
// traffic scored against a handshake-level model of the arbitration and counter rules.
module tb_fp_input_arbiter;

    localparam int PACK_W  = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] P1 = 64'hFEDC_BA98_7654_3210;

    localparam int PH_IDLE = 0;
    localparam int PH_CAPT = 1;
    localparam int PH_FWD  = 2;
    localparam int PH_REL  = 3;

    logic              CLK = 1'b0;
    logic              MR = 1'b0;
    logic              Send_in0, Send_in1, DEL0, DEL1;
    logic [PACK_W-1:0] PACKET_IN0, PACKET_IN1, PACKET_OUT;
    logic              Ack_out0, Ack_out1, Send_out;
    logic              Ack_in = 1'b0;
    logic              CNT_CLR = 1'b0;
    logic [CNT_W-1:0]  GNT_CNT0, GNT_CNT1, DROP_CNT;

    logic              sendDrv[2];
    logic              curDel[2];
    logic [63:0]       curPkt[2];

    assign Send_in0   = sendDrv[0];
    assign Send_in1   = sendDrv[1];
    assign DEL0       = curDel[0];
    assign DEL1       = curDel[1];
    assign PACKET_IN0 = curPkt[0];
    assign PACKET_IN1 = curPkt[1];

    fp_input_arbiter #(.PACK_W(PACK_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .MR(MR),
        .Send_in0(Send_in0), .PACKET_IN0(PACKET_IN0), .DEL0(DEL0), .Ack_out0(Ack_out0),
        .Send_in1(Send_in1), .PACKET_IN1(PACKET_IN1), .DEL1(DEL1), .Ack_out1(Ack_out1),
        .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT),
        .CNT_CLR(CNT_CLR), .GNT_CNT0(GNT_CNT0), .GNT_CNT1(GNT_CNT1), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Handshake-level model state
    int          mPhase, mCh, mLast, mDrop;
    int          mG[2];
    logic        mDel;
    logic [63:0] mPkt;
    int          grantLog[$];
    int          sndState[2];
    int          sent[2];

    typedef struct packed {
        logic        s0, d0, s1, d1, ai, clr;
        logic        ea0, ea1, eso;
        logic [63:0] epkt;
        logic [3:0]  eg0, eg1, edr;
    } vec_t;

    vec_t vecs[19];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    function automatic int satInc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic vec_t mkVec(input logic s0, d0, s1, d1, ai, clr, ea0, ea1, eso,
                                   input logic [63:0] epkt, input int g0, g1, dr);
        vec_t v;
        v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1; v.ai = ai; v.clr = clr;
        v.ea0 = ea0; v.ea1 = ea1; v.eso = eso; v.epkt = epkt;
        v.eg0 = g0[3:0]; v.eg1 = g1[3:0]; v.edr = dr[3:0];
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        sendDrv[0] = v.s0; curDel[0] = v.d0;
        sendDrv[1] = v.s1; curDel[1] = v.d1;
        Ack_in = v.ai; CNT_CLR = v.clr;
    endtask

    task automatic doReset(input bit checkValues);
        @(negedge CLK);
        MR = 1'b0;
        sendDrv[0] = 1'b0; sendDrv[1] = 1'b0;
        curDel[0] = 1'b0; curDel[1] = 1'b0;
        Ack_in = 1'b0; CNT_CLR = 1'b0;
        #1;
        if (checkValues) begin
            checkOutput("reset Send_out", Send_out, 0);
            checkOutput("reset Ack_out0", Ack_out0, 0);
            checkOutput("reset Ack_out1", Ack_out1, 0);
            checkOutput("reset PACKET_OUT", PACKET_OUT, 0);
            checkOutput("reset counters", {GNT_CNT0, GNT_CNT1, DROP_CNT}, 0);
        end
        @(negedge CLK);
        MR = 1'b1;
        mPhase = PH_IDLE; mLast = 1; mCh = 0; mDrop = 0; mG[0] = 0; mG[1] = 0;
        mDel = 1'b0; mPkt = '0;
        grantLog.delete();
        sndState[0] = 0; sndState[1] = 0; sent[0] = 0; sent[1] = 0;
    endtask

    // Evaluates the edge just passed from the inputs that were on the wires at that edge
    task automatic modelStep(input string tag);
        logic ea[2];
        logic eso;
        int   ch;
        ea[0] = 1'b0; ea[1] = 1'b0; eso = 1'b0;
        case (mPhase)
            PH_IDLE: begin
                if (sendDrv[0] || sendDrv[1]) begin
                    ch = (sendDrv[0] && sendDrv[1]) ? 1 - mLast : (sendDrv[1] ? 1 : 0);
                    mLast = ch; mCh = ch;
                    mPkt = curPkt[ch]; mDel = curDel[ch];
                    mG[ch] = satInc(mG[ch]);
                    ea[ch] = 1'b1;
                    grantLog.push_back(ch);
                    mPhase = PH_CAPT;
                end
            end
            PH_CAPT: begin
                if (sendDrv[mCh]) ea[mCh] = 1'b1;
                else if (mDel) begin
                    mDrop = satInc(mDrop);
                    mPhase = PH_IDLE;
                end else begin
                    eso = 1'b1;
                    mPhase = PH_FWD;
                end
            end
            PH_FWD: begin
                if (Ack_in) mPhase = PH_REL;
                else eso = 1'b1;
            end
            default: begin
                if (!Ack_in) mPhase = PH_IDLE;
            end
        endcase
        if (CNT_CLR) begin
            mG[0] = 0; mG[1] = 0; mDrop = 0;
        end
        checkOutput({tag, " Ack_out0"}, Ack_out0, ea[0]);
        checkOutput({tag, " Ack_out1"}, Ack_out1, ea[1]);
        checkOutput({tag, " Send_out"}, Send_out, eso);
        checkOutput({tag, " PACKET_OUT"}, PACKET_OUT, mPkt);
        checkOutput({tag, " GNT_CNT0"}, GNT_CNT0, mG[0]);
        checkOutput({tag, " GNT_CNT1"}, GNT_CNT1, mG[1]);
        checkOutput({tag, " DROP_CNT"}, DROP_CNT, mDrop);
    endtask

    // Reactive 4-phase senders and FP peer; zero-delay when rnd is 0
    task automatic runTraffic(input int max0, input int max1, input bit rnd, input int cycles, input string tag);
        bit   done;
        bit   allowed;
        bit   more;
        logic ackx;
        done = 1'b0;
        for (int i = 0; i < cycles + 400 && !done; i++) begin
            @(negedge CLK);
            modelStep(tag);
            for (int x = 0; x < 2; x++) begin
                allowed = (sent[x] < (x == 1 ? max1 : max0)) && (i < cycles);
                ackx = (x == 1) ? Ack_out1 : Ack_out0;
                if (sndState[x] == 2 && !ackx) sndState[x] = 0;
                if (sndState[x] == 1 && ackx && (!rnd || $urandom_range(2) != 0)) begin
                    sendDrv[x] = 1'b0;
                    sndState[x] = 2;
                end else if (sndState[x] == 0 && allowed && (!rnd || $urandom_range(3) == 0)) begin
                    curPkt[x] = {$urandom, $urandom};
                    curDel[x] = rnd && ($urandom_range(3) == 0);
                    sendDrv[x] = 1'b1;
                    sent[x]++;
                    sndState[x] = 1;
                end
            end
            if (Send_out && !Ack_in && (!rnd || $urandom_range(2) == 0)) Ack_in = 1'b1;
            else if (!Send_out && Ack_in && (!rnd || $urandom_range(2) == 0)) Ack_in = 1'b0;
            CNT_CLR = rnd && ($urandom_range(15) == 0);
            more = ((sent[0] < max0) || (sent[1] < max1)) && (i + 1 < cycles);
            done = !more && sndState[0] == 0 && sndState[1] == 0 && mPhase == PH_IDLE
                   && !Ack_in && !CNT_CLR && !sendDrv[0] && !sendDrv[1];
        end
        checkOutput({tag, " drained"}, done, 1);
    endtask

    initial begin
        sendDrv[0] = 1'b0; sendDrv[1] = 1'b0;
        curDel[0] = 1'b0; curDel[1] = 1'b0;
        curPkt[0] = P0; curPkt[1] = P1;

        //                 s0 d0 s1 d1 ai clr  a0 a1 so  pkt  g0 g1 dr
        vecs[0]  = mkVec(1, 0, 0, 0, 0, 0,   1, 0, 0,  P0,  1, 0, 0);
        vecs[1]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 1,  P0,  1, 0, 0);
        vecs[2]  = mkVec(0, 0, 0, 0, 1, 0,   0, 0, 0,  P0,  1, 0, 0);
        vecs[3]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0,  P0,  1, 0, 0);
        vecs[4]  = mkVec(0, 0, 1, 1, 0, 0,   0, 1, 0,  P1,  1, 1, 0);
        vecs[5]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0,  P1,  1, 1, 1);
        vecs[6]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0,  P1,  1, 1, 1);
        vecs[7]  = mkVec(1, 0, 0, 0, 1, 0,   1, 0, 0,  P0,  2, 1, 1);
        vecs[8]  = mkVec(0, 0, 0, 0, 1, 0,   0, 0, 1,  P0,  2, 1, 1);
        vecs[9]  = mkVec(0, 0, 0, 0, 1, 0,   0, 0, 0,  P0,  2, 1, 1);
        vecs[10] = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0,  P0,  2, 1, 1);
        vecs[11] = mkVec(1, 0, 1, 0, 0, 1,   0, 1, 0,  P1,  0, 0, 0);
        vecs[12] = mkVec(1, 0, 0, 0, 0, 0,   0, 0, 1,  P1,  0, 0, 0);
        vecs[13] = mkVec(1, 0, 0, 0, 1, 0,   0, 0, 0,  P1,  0, 0, 0);
        vecs[14] = mkVec(1, 0, 0, 0, 0, 0,   0, 0, 0,  P1,  0, 0, 0);
        vecs[15] = mkVec(1, 0, 0, 0, 0, 0,   1, 0, 0,  P0,  1, 0, 0);
        vecs[16] = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 1,  P0,  1, 0, 0);
        vecs[17] = mkVec(0, 0, 0, 0, 1, 0,   0, 0, 0,  P0,  1, 0, 0);
        vecs[18] = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0,  P0,  1, 0, 0);

        doReset(1'b1);
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            @(negedge CLK);
            checkOutput($sformatf("row%0d Ack_out0", i), Ack_out0, vecs[i].ea0);
            checkOutput($sformatf("row%0d Ack_out1", i), Ack_out1, vecs[i].ea1);
            checkOutput($sformatf("row%0d Send_out", i), Send_out, vecs[i].eso);
            checkOutput($sformatf("row%0d PACKET_OUT", i), PACKET_OUT, vecs[i].epkt);
            checkOutput($sformatf("row%0d GNT_CNT0", i), GNT_CNT0, vecs[i].eg0);
            checkOutput($sformatf("row%0d GNT_CNT1", i), GNT_CNT1, vecs[i].eg1);
            checkOutput($sformatf("row%0d DROP_CNT", i), DROP_CNT, vecs[i].edr);
        end

        $display("[TB] backpressure");
        doReset(1'b0);
        curPkt[0] = P0; curPkt[1] = P1;
        sendDrv[0] = 1'b1;
        @(negedge CLK);
        checkOutput("bp grant0", Ack_out0, 1);
        sendDrv[0] = 1'b0;
        sendDrv[1] = 1'b1;
        @(negedge CLK);
        checkOutput("bp Send_out up", Send_out, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checkOutput($sformatf("bp hold%0d Send_out", k), Send_out, 1);
            checkOutput($sformatf("bp hold%0d PACKET_OUT", k), PACKET_OUT, P0);
            checkOutput($sformatf("bp hold%0d Ack_out1", k), Ack_out1, 0);
        end
        Ack_in = 1'b1;
        @(negedge CLK);
        checkOutput("bp release Send_out", Send_out, 0);
        checkOutput("bp release Ack_out1", Ack_out1, 0);
        Ack_in = 1'b0;
        @(negedge CLK);
        checkOutput("bp no grant on idle return", Ack_out1, 0);
        @(negedge CLK);
        checkOutput("bp pending grant1", Ack_out1, 1);
        checkOutput("bp pending PACKET_OUT", PACKET_OUT, P1);
        sendDrv[1] = 1'b0;

        $display("[TB] reset mid-transfer");
        doReset(1'b0);
        curPkt[0] = P0;
        sendDrv[0] = 1'b1;
        @(negedge CLK);
        sendDrv[0] = 1'b0;
        @(negedge CLK);
        checkOutput("mr Send_out before", Send_out, 1);
        #2 MR = 1'b0;
        #1;
        checkOutput("mr Send_out", Send_out, 0);
        checkOutput("mr Ack_out0", Ack_out0, 0);
        checkOutput("mr Ack_out1", Ack_out1, 0);
        checkOutput("mr PACKET_OUT", PACKET_OUT, 0);
        checkOutput("mr GNT_CNT0", GNT_CNT0, 0);
        sendDrv[0] = 1'b1;
        sendDrv[1] = 1'b1;
        @(negedge CLK);
        MR = 1'b1;
        @(negedge CLK);
        checkOutput("mr first tie Ack_out0", Ack_out0, 1);
        checkOutput("mr first tie Ack_out1", Ack_out1, 0);

        $display("[TB] contention");
        doReset(1'b0);
        runTraffic(4, 4, 1'b0, 200, "contention");
        checkOutput("contention grant count", grantLog.size(), 8);
        for (int k = 0; k < grantLog.size(); k++)
            checkOutput($sformatf("contention order%0d", k), grantLog[k], k % 2);
        checkOutput("contention GNT_CNT0", GNT_CNT0, 4);
        checkOutput("contention GNT_CNT1", GNT_CNT1, 4);

        $display("[TB] saturation");
        doReset(1'b0);
        runTraffic((1 << CNT_W) + 3, 0, 1'b0, 400, "saturate");
        checkOutput("saturate GNT_CNT0", GNT_CNT0, 4'hF);
        sendDrv[0] = 1'b1;
        CNT_CLR = 1'b1;
        @(negedge CLK);
        checkOutput("clear+grant Ack_out0", Ack_out0, 1);
        checkOutput("clear+grant GNT_CNT0", GNT_CNT0, 0);
        sendDrv[0] = 1'b0;
        CNT_CLR = 1'b0;

        $display("[TB] random traffic");
        doReset(1'b0);
        runTraffic(1000000, 1000000, 1'b1, 3000, "random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
